video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Raster timing generator feeding the `render` stage and the downstream HDMI path. It produces `hcount_out` and `vcount_out` for a 1280x720@60 raster (1650x750 total), along with sync strobes, the active-draw flag and a one-cycle `frame_start_out` pulse. `frame_start_out` drives `render`'s `start_in`. All outputs are mutually aligned, so the pixel colour from `render` and the sync strobes stay in lockstep on the way to TMDS.

## Interface
Parameters:
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, 110: horizontal front porch
- `H_SYNC`, 40: hsync width
- `H_BP`, 220: horizontal back porch
- `V_ACTIVE`, 720: visible lines
- `V_FP`, 5: vertical front porch
- `V_SYNC`, 5: vsync width
- `V_BP`, 20: vertical back porch

Ports:
- `clk_in`  in  1  pixel clock (74.25 MHz)
- `rst_n_in`  in  1  reset, asynchronous, active-low
- `ce_in`  in  1  count enable; counters hold when low
- `hcount_out`  out  11  horizontal position, 0..H_TOTAL-1
- `vcount_out`  out  10  vertical position, 0..V_TOTAL-1
- `hsync_out`  out  1  horizontal sync, active-high
- `vsync_out`  out  1  vertical sync, active-high
- `active_draw_out`  out  1  high when in the visible region
- `frame_start_out`  out  1  one-cycle pulse at (H_ACTIVE, V_ACTIVE)
- `frame_count_out`  out  6  frames since reset (only with the macro)

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1650.
  - V_TOTAL = 750.
- Counting on each `ce_in`-qualified cycle:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Decoded outputs are registered from the *next* counter values, so every output describes the same (h, v) as `hcount_out`/`vcount_out`.
- `hsync_out` is high for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1390, 1429].
- `vsync_out` is high for vcount in [725, 729], over the full line, toggling at hcount 0.
- `active_draw_out` = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- `frame_start_out` is high for exactly one enabled cycle, when hcount==1280 and vcount==720.
- `ce_in` low:
  - All registers hold.
  - `frame_start_out` is forced low for those cycles, so a held position never re-pulses.
- Counter widths are sized for the defaults. Parameter sets with H_TOTAL > 2048 or V_TOTAL > 1024 are illegal; an `initial` assertion checks this.

## Timing
- Reset (`rst_n_in` low, asynchronous): counters 0, all strobes 0, `frame_count_out` 0.
- First rising edge after release with `ce_in` high: outputs show (0, 0) with `active_draw_out` = 1. There is no dead cycle.
- Latency is 0 between counter and decode; all outputs change on the same edge.
- A frame is 1,237,500 enabled cycles.
- `frame_start_out` period is exactly 1,237,500 enabled cycles.
- Reset asserted mid-frame: immediate return to (0, 0) with no pulse emitted. The first `frame_start_out` after release comes 1280+720*1650 enabled cycles later.
- Simultaneous line and frame wrap: vcount wraps 749→0 on the same edge hcount wraps 1649→0.

## Configuration
- Macro: `VIDEO_TIMING_FRAME_COUNT_EN`.
- Defined:
  - `frame_count_out` exists.
  - It increments (mod 64) on the edge where the raster wraps (1649, 749)→(0, 0).
  - It is 0 after reset.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `video_pkg`:
  - 720p default timing constants.
  - `H_TOTAL`/`V_TOTAL` derivation.
  - Count widths `HCOUNT_W` = 11, `VCOUNT_W` = 10.
  - These are shared with `render` and the HDMI encoder.
- One sub-module, `wrap_counter` (parameterised width and terminal value):
  - Instantiated twice: horizontal counter enabled by `ce_in`; vertical counter enabled by `ce_in` and the horizontal wrap.
  - Its wrap flag is an output.
- Decode logic and the optional frame counter live in the top.

## Test plan
- Reset then `ce_in` = 1 for 1650 cycles → hcount 0..1649; `hsync_out` high exactly on cycles 1390–1429; `active_draw_out` high for 0–1279; vcount becomes 1 on cycle 1650.
- Run 2 full frames → `frame_start_out` high exactly twice, 1,237,500 cycles apart, each time at (1280, 720); `vsync_out` high for lines 725–729 only.
- Toggle `ce_in` low for 3 cycles while at (1280, 720) → position holds; `frame_start_out` pulses only once; counting resumes at 1281.
- Assert `rst_n_in` asynchronously at (800, 400), mid-cycle → outputs go 0 before the next edge; after release, counting restarts at (0, 0).
- With `VIDEO_TIMING_FRAME_COUNT_EN`, run 65 frames → `frame_count_out` reads 1 (wrapped through 63→0), incrementing at each (0, 0).
- Check the wrap edge (1649, 749)→(0, 0) → `active_draw_out` rises 0→1 and `vsync_out` stays 0.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared 720p60 raster constants and count widths for the timing generator,
// render stage and HDMI encoder.
package video_pkg;
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HCOUNT_W      = 11;
  localparam int VCOUNT_W      = 10;
  localparam int FRAME_COUNT_W = 6;
endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from video_timing_gen to render / HDMI.
// frame_count_out exists only with VIDEO_TIMING_FRAME_COUNT_EN.
interface video_timing_if;
  import video_pkg::*;

  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                hsync_out;
  logic                vsync_out;
  logic                active_draw_out;
  logic                frame_start_out;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [FRAME_COUNT_W-1:0] frame_count_out;
`endif

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out, active_draw_out, frame_start_out
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    , output frame_count_out
`endif
  );

  modport slave (
    input hcount_out, vcount_out, hsync_out, vsync_out, active_draw_out, frame_start_out
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    , input frame_count_out
`endif
  );
endinterface

// File: rtl/video_timing_gen_wrap_counter.sv
// Enabled up-counter that wraps to zero after TERM; exposes the next value so
// callers can decode from it with zero latency.
module wrap_counter #(
  parameter int WIDTH = 11,
  parameter int TERM  = 1649
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);
  localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERM);

  logic [WIDTH-1:0] count_q, count_d;

  assign wrap_o = (count_q == TERM_C);

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = wrap_o ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus registered sync/active/frame decode.
// Optional frame counter enabled by VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  ce_in,
  video_timing_if.master        vt
);
  import video_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 2048 || V_TOT > 1024) begin : g_param_check
    $error("video_timing_gen: raster totals exceed counter widths");
  end

  localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT_C  = HCOUNT_W'(H_ACTIVE);
  localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VCOUNT_W-1:0] V_ACT_C  = VCOUNT_W'(V_ACTIVE);

  logic [HCOUNT_W-1:0] h_count, h_next;
  logic [VCOUNT_W-1:0] v_count, v_next;
  logic                h_wrap, v_wrap, h_en, v_en;
  logic                running_q, running_d;
  logic                hsync_q, vsync_q, active_q, fstart_q;
  logic                hsync_d, vsync_d, active_d, fstart_d;

  // The first enabled edge after reset presents (0,0) instead of advancing.
  assign running_d = running_q | ce_in;
  assign h_en      = ce_in & running_q;
  assign v_en      = h_en & h_wrap;

  wrap_counter #(.WIDTH(HCOUNT_W), .TERM(H_TOT - 1)) u_hcnt (
    .clk_i(clk_in), .rst_n_i(rst_n_in), .en_i(h_en),
    .count_o(h_count), .next_o(h_next), .wrap_o(h_wrap)
  );

  wrap_counter #(.WIDTH(VCOUNT_W), .TERM(V_TOT - 1)) u_vcnt (
    .clk_i(clk_in), .rst_n_i(rst_n_in), .en_i(v_en),
    .count_o(v_count), .next_o(v_next), .wrap_o(v_wrap)
  );

  always_comb begin
    hsync_d  = (h_next >= HS_START) && (h_next <= HS_END);
    vsync_d  = (v_next >= VS_START) && (v_next <= VS_END);
    active_d = (h_next < H_ACT_C) && (v_next < V_ACT_C);
    fstart_d = ce_in && (h_next == H_ACT_C) && (v_next == V_ACT_C);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      running_q <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      active_q  <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      running_q <= running_d;
      fstart_q  <= fstart_d;
      if (ce_in) begin
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        active_q <= active_d;
      end
    end
  end

  assign vt.hcount_out      = h_count;
  assign vt.vcount_out      = v_count;
  assign vt.hsync_out       = hsync_q;
  assign vt.vsync_out       = vsync_q;
  assign vt.active_draw_out = active_q;
  assign vt.frame_start_out = fstart_q;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [FRAME_COUNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = (v_en && v_wrap) ? frame_cnt_q + 1'b1 : frame_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) frame_cnt_q <= '0;
    else           frame_cnt_q <= frame_cnt_d;
  end

  assign vt.frame_count_out = frame_cnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a small-raster instance for multi-frame
// behaviour and a default 720p instance for first-line boundaries.
module tb_video_timing_gen;
  typedef struct {
    int HA, HFP, HS, HBP, VA, VFP, VS, VBP;
  } prm_t;

  typedef struct {
    int h; int v; bit st; bit hs; bit vs; bit ad; bit fs; int fc;
  } mst_t;

  localparam prm_t PS = '{16, 4, 3, 5, 10, 2, 2, 3};          // 28 x 17, 476 per frame
  localparam prm_t PD = '{1280, 110, 40, 220, 720, 5, 5, 20}; // 1650 x 750

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  video_timing_if vs_if ();
  video_timing_if vd_if ();

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (.clk_in(clk), .rst_n_in(rst_n), .ce_in(ce), .vt(vs_if));

  video_timing_gen dut_d (.clk_in(clk), .rst_n_in(rst_n), .ce_in(ce), .vt(vd_if));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fs_n = 0;
  int fs_t[2];
  mst_t ms, md;
  mst_t q_s[$];
  mst_t q_d[$];

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic mst_t advance(mst_t m, prm_t p, bit c, bit r);
    int ht, vt;
    ht = p.HA + p.HFP + p.HS + p.HBP;
    vt = p.VA + p.VFP + p.VS + p.VBP;
    if (!r) begin
      m.h = 0; m.v = 0; m.st = 0; m.hs = 0; m.vs = 0; m.ad = 0; m.fs = 0; m.fc = 0;
      return m;
    end
    if (!c) begin
      m.fs = 0;
      return m;
    end
    if (!m.st) begin
      m.st = 1; m.h = 0; m.v = 0;
    end else if (m.h == ht - 1) begin
      m.h = 0;
      if (m.v == vt - 1) begin
        m.v = 0;
        m.fc = (m.fc + 1) % 64;
      end else m.v++;
    end else m.h++;
    m.hs = (m.h >= p.HA + p.HFP) && (m.h < p.HA + p.HFP + p.HS);
    m.vs = (m.v >= p.VA + p.VFP) && (m.v < p.VA + p.VFP + p.VS);
    m.ad = (m.h < p.HA) && (m.v < p.VA);
    m.fs = (m.h == p.HA) && (m.v == p.VA);
    return m;
  endfunction

  task automatic step(bit c, bit r);
    @(negedge clk);
    ce = c;
    rst_n = r;
    ms = advance(ms, PS, c, r);
    md = advance(md, PD, c, r);
    q_s.push_back(ms);
    q_d.push_back(md);
  endtask

  // Monitor: one expected entry per clock edge for each instance
  initial begin
    mst_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (vs_if.frame_start_out === 1'b1) begin
        if (fs_n < 2) fs_t[fs_n] = cyc;
        fs_n++;
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check($sformatf("s_hcount@%0d", cyc), int'(vs_if.hcount_out), e.h);
        check($sformatf("s_vcount@%0d", cyc), int'(vs_if.vcount_out), e.v);
        check($sformatf("s_hsync@%0d", cyc), int'(vs_if.hsync_out), int'(e.hs));
        check($sformatf("s_vsync@%0d", cyc), int'(vs_if.vsync_out), int'(e.vs));
        check($sformatf("s_active@%0d", cyc), int'(vs_if.active_draw_out), int'(e.ad));
        check($sformatf("s_fstart@%0d", cyc), int'(vs_if.frame_start_out), int'(e.fs));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check($sformatf("s_fcount@%0d", cyc), int'(vs_if.frame_count_out), e.fc);
`endif
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        check($sformatf("d_hcount@%0d", cyc), int'(vd_if.hcount_out), e.h);
        check($sformatf("d_vcount@%0d", cyc), int'(vd_if.vcount_out), e.v);
        check($sformatf("d_hsync@%0d", cyc), int'(vd_if.hsync_out), int'(e.hs));
        check($sformatf("d_vsync@%0d", cyc), int'(vd_if.vsync_out), int'(e.vs));
        check($sformatf("d_active@%0d", cyc), int'(vd_if.active_draw_out), int'(e.ad));
        check($sformatf("d_fstart@%0d", cyc), int'(vd_if.frame_start_out), int'(e.fs));
      end
    end
  end

  initial begin
    int base;
    int n;
    ms = advance(ms, PS, 1'b1, 1'b0);
    md = advance(md, PD, 1'b1, 1'b0);

    repeat (3) step(1'b1, 1'b0);

    // Release; first edge presents (0,0). One full default line.
    step(1'b1, 1'b1);
    base = cyc;
    repeat (1649) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(posedge clk); #2;
    check("fs_first_cycle", fs_t[0], base + 1 + 16 + 10 * 28);
    check("fs_period", fs_t[1] - fs_t[0], 476);

    // Hold at (16,10) for three disabled cycles
    n = 0;
    while (!(ms.h == 16 && ms.v == 10) && n < 2000) begin
      step(1'b1, 1'b1);
      n++;
    end
    check("reach_frame_start_timeout", int'(n < 2000), 1);
    repeat (3) step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1);

    // Asynchronous reset mid-cycle at (8,5)
    n = 0;
    while (!(ms.h == 8 && ms.v == 5) && n < 2000) begin
      step(1'b1, 1'b1);
      n++;
    end
    check("reach_8_5_timeout", int'(n < 2000), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_s_hcount", int'(vs_if.hcount_out), 0);
    check("async_s_vcount", int'(vs_if.vcount_out), 0);
    check("async_s_active", int'(vs_if.active_draw_out), 0);
    check("async_s_hsync", int'(vs_if.hsync_out), 0);
    check("async_s_fstart", int'(vs_if.frame_start_out), 0);
    check("async_d_hcount", int'(vd_if.hcount_out), 0);
    ms = advance(ms, PS, 1'b1, 1'b0);
    md = advance(md, PD, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);

    // 65 small frames after restart, including the 65th wrap edge
    repeat (65 * 476 + 1) step(1'b1, 1'b1);
    @(posedge clk); #2;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("frame_count_after_65", int'(vs_if.frame_count_out), 1);
`endif
    check("s_pos_after_65_h", int'(vs_if.hcount_out), 0);
    check("s_pos_after_65_v", int'(vs_if.vcount_out), 0);
    check("scoreboard_drained", q_s.size() + q_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
